// File: rtl/sort_pkg.sv
// Shared constants and helpers for the bitonic sorter.
// num_stages gives the compare-exchange stage count for a power-of-two DEPTH.
package sort_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 8;

  function automatic int num_stages(input int depth);
    int lg;
    lg = $clog2(depth);
    return (lg * (lg + 32'sd1)) / 32'sd2;
  endfunction

endpackage

// File: rtl/sort_cas.sv
// Registered two-input compare-exchange with signed comparison.
// dir=1 puts the larger key on out_a; dir=0 puts the smaller key on out_a.
module sort_cas
  import sort_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dir,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] out_a,
  output logic signed [WIDTH-1:0] out_b
);

  logic                    swap_s;
  logic signed [WIDTH-1:0] a_nxt_s;
  logic signed [WIDTH-1:0] b_nxt_s;

  // Decide whether the pair must be exchanged; relational compare only, no subtraction.
  always_comb begin
    swap_s  = 1'b0;
    a_nxt_s = a;
    b_nxt_s = b;
    if (dir) begin
      swap_s = (b > a);
    end else begin
      swap_s = (a > b);
    end
    if (swap_s) begin
      a_nxt_s = b;
      b_nxt_s = a;
    end else begin
      a_nxt_s = a;
      b_nxt_s = b;
    end
  end

  // Stage register for the exchanged pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_a <= {WIDTH{1'b0}};
      out_b <= {WIDTH{1'b0}};
    end else begin
      out_a <= a_nxt_s;
      out_b <= b_nxt_s;
    end
  end

endmodule

// File: rtl/sort_top.sv
// Fully pipelined bitonic sorter: an input register followed by S registered
// compare-exchange stages; sorted[0] holds the maximum, sorted[DEPTH-1] the minimum.
module sort_top
  import sort_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic signed [WIDTH-1:0] unsorted [DEPTH-1:0],
  output logic signed [WIDTH-1:0] sorted   [DEPTH-1:0],
  output logic                    valid_out
);

  localparam int LOG_D = $clog2(DEPTH);
  localparam int S     = num_stages(DEPTH);

  logic signed [WIDTH-1:0] in_r  [DEPTH];
  logic signed [WIDTH-1:0] stg_s [S+1][DEPTH];
  logic [S:0]              valid_r;

  // Input capture register so no input reaches the network combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        in_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        in_r[i] <= unsorted[i];
      end
    end
  end

  // Valid shift register tracking the data through capture and every stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= {(S + 1){1'b0}};
    end else begin
      valid_r <= {valid_r[S-1:0], valid_in};
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_io
    assign stg_s[0][i] = in_r[i];
    assign sorted[i]   = stg_s[S][i];
  end

  assign valid_out = valid_r[S];

  // Stage (p,q) merges blocks of 2^(p+1) with partner distance 2^(p-q);
  // blocks with (i & K) == 0 sort descending, so the final merge is descending.
  for (genvar p = 0; p < LOG_D; p++) begin : g_merge
    for (genvar q = 0; q <= p; q++) begin : g_step
      localparam int SI = (p * (p + 1)) / 2 + q;
      localparam int K  = 1 << (p + 1);
      localparam int J  = 1 << (p - q);
      for (genvar i = 0; i < DEPTH; i++) begin : g_elem
        if ((i & J) == 0) begin : g_cas
          localparam logic DESC = ((i & K) == 0) ? 1'b1 : 1'b0;
          sort_cas #(
            .WIDTH(WIDTH)
          ) u_cas (
            .clk  (clk),
            .rst  (rst),
            .dir  (DESC),
            .a    (stg_s[SI][i]),
            .b    (stg_s[SI][i+J]),
            .out_a(stg_s[SI+1][i]),
            .out_b(stg_s[SI+1][i+J])
          );
        end
      end
    end
  end

endmodule

// File: tb/tb_sort_top.sv
// Scoreboard bench for sort_top (WIDTH=32, DEPTH=8): the driver queues hand-sorted
// expectations with their sampling cycle, and a monitor checks data and latency.
module tb_sort_top;

  localparam int W = 32;
  localparam int D = 8;
  localparam int S = 6;

  typedef logic [D-1:0][W-1:0] pvec_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                valid_in;
  logic signed [W-1:0] unsorted [D-1:0];
  logic signed [W-1:0] sorted   [D-1:0];
  logic                valid_out;

  int    checks = 0;
  int    errors = 0;
  int    cycle_cnt = 0;
  pvec_t exp_q[$];
  int    cyc_q[$];

  localparam logic [W-1:0] MINV = 32'h8000_0000;
  localparam logic [W-1:0] MAXV = 32'h7FFF_FFFF;

  sort_top #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .unsorted (unsorted),
    .sorted   (sorted),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic pvec_t mk(input logic signed [W-1:0] e7, e6, e5, e4, e3, e2, e1, e0);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  function automatic pvec_t dut_vec();
    pvec_t v;
    for (int i = 0; i < D; i++) v[i] = sorted[i];
    return v;
  endfunction

  task automatic send(input pvec_t vin, input pvec_t vexp);
    @(negedge clk);
    for (int i = 0; i < D; i++) unsorted[i] = vin[i];
    valid_in = 1'b1;
    exp_q.push_back(vexp);
    cyc_q.push_back(cycle_cnt + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  // Monitor: every valid_out must match the queue head, at exactly S cycles latency.
  always @(negedge clk) begin
    if (rst) begin
      if (valid_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid_out: got sorted=%h, required no output", dut_vec());
        end else begin
          pvec_t e;
          int    c;
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          if (dut_vec() !== e) begin
            errors++;
            $display("FAIL sorted_data: got %h, required %h", dut_vec(), e);
          end
          checks++;
          if (cycle_cnt - c != S) begin
            errors++;
            $display("FAIL latency: got %0d, required %0d", cycle_cnt - c, S);
          end
        end
      end else if (cyc_q.size() > 0 && (cycle_cnt - cyc_q[0]) >= S) begin
        checks++;
        errors++;
        $display("FAIL missing_valid_out: got valid_out=0, required 1 for %h", exp_q[0]);
        void'(exp_q.pop_front());
        void'(cyc_q.pop_front());
      end
    end
  end

  task automatic check_reset_state(input string name);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL %s_valid: got %b, required 0", name, valid_out);
    end
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL %s_sorted: got %h, required 0", name, dut_vec());
    end
  endtask

  initial begin
    rst      = 1'b0;
    valid_in = 1'b0;
    for (int i = 0; i < D; i++) unsorted[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b1;

    send(mk(0, 0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0));
    idle(2);
    send(mk(7, 7, 7, 7, 7, 7, 7, 7), mk(7, 7, 7, 7, 7, 7, 7, 7));
    send(mk(-5, -5, -5, -5, -5, -5, -5, -5), mk(-5, -5, -5, -5, -5, -5, -5, -5));
    idle(1);
    send(mk(-10, 5, 0, -3, 2, 7, -1, 4), mk(-10, -3, -1, 0, 2, 4, 5, 7));
    idle(1);
    send(mk(MINV, MAXV, 0, -1, 1, 123, -123, 0), mk(MINV, -123, -1, 0, 0, 1, 123, MAXV));
    idle(10);

    // Six back-to-back vectors.
    send(mk(3, 1, 4, 1, 5, 9, 2, 6), mk(1, 1, 2, 3, 4, 5, 6, 9));
    send(mk(8, 7, 6, 5, 4, 3, 2, 1), mk(1, 2, 3, 4, 5, 6, 7, 8));
    send(mk(1, 2, 3, 4, 5, 6, 7, 8), mk(1, 2, 3, 4, 5, 6, 7, 8));
    send(mk(-1, -1, -1, -1, -2, -2, -2, -2), mk(-2, -2, -2, -2, -1, -1, -1, -1));
    send(mk(100, -100, 50, -50, 25, -25, 0, 0), mk(-100, -50, -25, 0, 0, 25, 50, 100));
    send(mk(MAXV, MAXV, MINV, MINV, 0, 1, -1, 2), mk(MINV, MINV, -1, 0, 1, 2, MAXV, MAXV));
    idle(10);

    // Three vectors in flight, then an asynchronous reset discards them.
    send(mk(3, 1, 4, 1, 5, 9, 2, 6), mk(1, 1, 2, 3, 4, 5, 6, 9));
    send(mk(8, 7, 6, 5, 4, 3, 2, 1), mk(1, 2, 3, 4, 5, 6, 7, 8));
    send(mk(9, 9, 9, 9, 9, 9, 9, 9), mk(9, 9, 9, 9, 9, 9, 9, 9));
    @(posedge clk);
    #2;
    rst      = 1'b0;
    valid_in = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst = 1'b1;
    idle(12);

    send(mk(-10, 5, 0, -3, 2, 7, -1, 4), mk(-10, -3, -1, 0, 2, 4, 5, 7));
    idle(12);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end

endmodule
